// File: rtl/modulo_controle_disparo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : modulo_controle_disparo
//  Brief    : Shot controller for the naval-battle game. Debounces the fire
//             button, latches and validates a coordinate on the 7x5 board,
//             checks it against the ship map and maintains the shot and hit
//             maps, the status code, the shot budget and the game-over flag.
//  Options  : SHOT_LIMIT_EN - when defined, builds the shot budget counter;
//             when undefined, shots_left is held at MAX_SHOTS and the game
//             ends only when every ship is sunk.
//  Revision : 1.0 - initial release
// ============================================================================
module modulo_controle_disparo #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_SHOTS       = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        button_fire,
    input  logic [5:0]  coord_at,
    input  logic [34:0] ship_map,
    output logic [34:0] shot_map,
    output logic [34:0] hit_map,
    output logic [1:0]  status,
    output logic [3:0]  shots_left,
    output logic        shot_done,
    output logic        game_over
);

    localparam int              CNT_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]      SHOTS_INIT = 4'(MAX_SHOTS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        UPDATE = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             sync_a;
    logic             sync_b;
    logic             db_level;
    logic [CNT_W-1:0] db_cnt;
    logic             armed;
    logic             press;

    logic [5:0]       coord_q;
    logic             valid_q;
    logic [5:0]       idx_q;
    logic             repeat_q;
    logic             ship_q;

    logic [2:0]       row;
    logic [2:0]       col;
    logic             valid_c;
    logic [5:0]       idx_c;
    logic [5:0]       idx_safe;

    logic             accept;
    logic [34:0]      cell_mask;
    logic [34:0]      shot_upd;
    logic [34:0]      hit_upd;
    logic             all_sunk;
    logic             out_of_shots;

    // Two-flop synchronizer; resets to "pressed" so that a button held
    // through reset never looks like a fresh release-then-press.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= button_fire;
            sync_b <= sync_a;
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing
    // samples; a press pulse is only issued once a released level was seen.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            db_level <= 1'b1;
            db_cnt   <= '0;
            armed    <= 1'b0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b) begin
                armed <= 1'b1;
            end
            if (sync_b == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                db_level <= sync_b;
                db_cnt   <= '0;
                press    <= armed & ~sync_b;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Coordinate decode of the latched coordinate (used during CHECK).
    assign row      = coord_q[5:3];
    assign col      = coord_q[2:0];
    assign valid_c  = (row <= 3'd6) && (col <= 3'd4);
    assign idx_c    = 6'd34 - ({3'b000, row} * 6'd5 + {3'b000, col});
    assign idx_safe = valid_c ? idx_c : 6'd0;

    // Update values computed from the CHECK results (used during UPDATE).
    assign accept    = valid_q & ~repeat_q;
    assign cell_mask = 35'd1 << idx_q;
    assign shot_upd  = shot_map | (accept ? cell_mask : 35'd0);
    assign hit_upd   = hit_map  | ((accept & ship_q) ? cell_mask : 35'd0);
    assign all_sunk  = (hit_upd == ship_map) && (ship_map != 35'd0);

`ifdef SHOT_LIMIT_EN
    logic [3:0] left_upd;

    assign left_upd     = accept ? (shots_left - 4'd1) : shots_left;
    assign out_of_shots = (left_upd == 4'd0);

    // Shot budget: consumed only by valid, non-repeated shots.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            shots_left <= SHOTS_INIT;
        end else if (state == UPDATE) begin
            shots_left <= left_upd;
        end
    end
`else
    assign out_of_shots = 1'b0;
    assign shots_left   = SHOTS_INIT;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and Moore outputs.
    always_comb begin
        state_next = state;
        shot_done  = 1'b0;
        game_over  = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = UPDATE;
            end
            UPDATE: begin
                shot_done  = 1'b1;
                state_next = (all_sunk || out_of_shots) ? OVER : IDLE;
            end
            OVER: begin
                game_over = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch coordinate, register check results, commit the shot.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            coord_q  <= 6'd0;
            valid_q  <= 1'b0;
            idx_q    <= 6'd0;
            repeat_q <= 1'b0;
            ship_q   <= 1'b0;
            shot_map <= 35'd0;
            hit_map  <= 35'd0;
            status   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        coord_q <= coord_at;
                    end
                end
                CHECK: begin
                    valid_q  <= valid_c;
                    idx_q    <= idx_safe;
                    repeat_q <= valid_c & shot_map[idx_safe];
                    ship_q   <= valid_c & ship_map[idx_safe];
                end
                UPDATE: begin
                    shot_map <= shot_upd;
                    hit_map  <= hit_upd;
                    if (!accept) begin
                        status <= 2'b11;
                    end else if (ship_q) begin
                        status <= 2'b10;
                    end else begin
                        status <= 2'b01;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_modulo_controle_disparo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_modulo_controle_disparo
//  Brief    : Directed, scoreboard-based bench for modulo_controle_disparo.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_modulo_controle_disparo;

    localparam int DEB = 4;
`ifdef SHOT_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    typedef struct {
        logic [1:0]  status;
        logic [34:0] shot;
        logic [34:0] hit;
        logic [3:0]  left;
        logic        over;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        btn_a;
    logic        btn_b;
    logic [5:0]  coord;
    logic [34:0] ship;
    logic        sel;

    logic [34:0] shot_a, hit_a, shot_b, hit_b;
    logic [1:0]  status_a, status_b;
    logic [3:0]  left_a, left_b;
    logic        done_a, done_b, over_a, over_b;

    logic [34:0] obs_shot, obs_hit;
    logic [1:0]  obs_status;
    logic [3:0]  obs_left;
    logic        obs_done, obs_over;

    int checks    = 0;
    int failures  = 0;
    int done_total = 0;
    int exp_done  = 0;

    exp_t        sb[$];
    logic [34:0] m_shot, m_hit;
    logic [1:0]  m_status;
    logic [3:0]  m_left;
    logic        m_over;

    always #5 clk = ~clk;

    modulo_controle_disparo #(.DEBOUNCE_CYCLES(DEB), .MAX_SHOTS(15)) dut_a (
        .clk(clk), .clr(clr), .button_fire(btn_a), .coord_at(coord), .ship_map(ship),
        .shot_map(shot_a), .hit_map(hit_a), .status(status_a), .shots_left(left_a),
        .shot_done(done_a), .game_over(over_a)
    );

    modulo_controle_disparo #(.DEBOUNCE_CYCLES(DEB), .MAX_SHOTS(2)) dut_b (
        .clk(clk), .clr(clr), .button_fire(btn_b), .coord_at(coord), .ship_map(ship),
        .shot_map(shot_b), .hit_map(hit_b), .status(status_b), .shots_left(left_b),
        .shot_done(done_b), .game_over(over_b)
    );

    always_comb begin
        obs_shot   = sel ? shot_b   : shot_a;
        obs_hit    = sel ? hit_b    : hit_a;
        obs_status = sel ? status_b : status_a;
        obs_left   = sel ? left_b   : left_a;
        obs_done   = sel ? done_b   : done_a;
        obs_over   = sel ? over_b   : over_a;
    end

    always @(negedge clk) begin
        if (done_a) done_total = done_total + 1;
        if (done_b) done_total = done_total + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag, input logic [3:0] max);
        check({tag, ".shot"},   64'(obs_shot),   64'd0);
        check({tag, ".hit"},    64'(obs_hit),    64'd0);
        check({tag, ".status"}, 64'(obs_status), 64'd0);
        check({tag, ".left"},   64'(obs_left),   64'(max));
        check({tag, ".done"},   64'(obs_done),   64'd0);
        check({tag, ".over"},   64'(obs_over),   64'd0);
    endtask

    task automatic model_reset(input logic [3:0] max);
        m_shot   = 35'd0;
        m_hit    = 35'd0;
        m_status = 2'b00;
        m_left   = max;
        m_over   = 1'b0;
    endtask

    task automatic push_expect(input logic [5:0] c);
        int row;
        int col;
        int b;
        row = int'(c[5:3]);
        col = int'(c[2:0]);
        if (row > 6 || col > 4) begin
            m_status = 2'b11;
        end else begin
            b = 34 - (5 * row + col);
            if (m_shot[b]) begin
                m_status = 2'b11;
            end else begin
                m_shot[b] = 1'b1;
                if (ship[b]) begin
                    m_hit[b] = 1'b1;
                    m_status = 2'b10;
                end else begin
                    m_status = 2'b01;
                end
                if (LIMIT) m_left = m_left - 4'd1;
            end
        end
        m_over = ((m_hit == ship) && (ship != 35'd0)) || (LIMIT && (m_left == 4'd0));
        sb.push_back('{m_status, m_shot, m_hit, m_left, m_over});
    endtask

    task automatic set_btn(input logic v);
        if (sel) btn_b = v;
        else     btn_a = v;
    endtask

    // Press and hold the selected button, wait for resolution, release.
    task automatic fire(input string tag, input logic [5:0] c, input bit resolves);
        exp_t e;
        bit   seen;
        coord = c;
        if (resolves) push_expect(c);
        set_btn(1'b0);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (obs_done) seen = 1'b1;
        end
        if (resolves) begin
            check({tag, ".done_seen"}, 64'(seen), 64'd1);
            check({tag, ".over_at_done"}, 64'(obs_over), 64'd0);
            @(negedge clk);
            e = sb.pop_front();
            check({tag, ".status"}, 64'(obs_status), 64'(e.status));
            check({tag, ".shot"},   64'(obs_shot),   64'(e.shot));
            check({tag, ".hit"},    64'(obs_hit),    64'(e.hit));
            check({tag, ".left"},   64'(obs_left),   64'(e.left));
            check({tag, ".over"},   64'(obs_over),   64'(e.over));
            exp_done++;
        end else begin
            check({tag, ".no_done"}, 64'(seen),       64'd0);
            check({tag, ".status"},  64'(obs_status), 64'(m_status));
            check({tag, ".shot"},    64'(obs_shot),   64'(m_shot));
            check({tag, ".hit"},     64'(obs_hit),    64'(m_hit));
            check({tag, ".left"},    64'(obs_left),   64'(m_left));
            check({tag, ".over"},    64'(obs_over),   64'd1);
        end
        repeat (4) @(negedge clk);
        set_btn(1'b1);
        repeat (12) @(negedge clk);
        check({tag, ".done_count"}, 64'(done_total), 64'(exp_done));
    endtask

    initial begin
        clr   = 1'b0;
        btn_a = 1'b1;
        btn_b = 1'b1;
        coord = 6'd0;
        sel   = 1'b0;
        ship  = 35'd0;
        ship[34] = 1'b1;
        ship[0]  = 1'b1;

        // Reset state on the main instance.
        repeat (3) @(negedge clk);
        check_reset("rst_a", 4'd15);
        clr = 1'b1;
        repeat (4) @(negedge clk);
        check_reset("idle_a", 4'd15);
        model_reset(4'd15);

        // Hit, repeat, invalid row, invalid column.
        fire("hit34",   6'b000_000, 1'b1);
        fire("repeat",  6'b000_000, 1'b1);
        fire("bad_row", 6'b111_000, 1'b1);
        fire("bad_col", 6'b000_101, 1'b1);

        // Bouncing button followed by a stable press: exactly one shot.
        coord = 6'b000_001;
        for (int i = 0; i < 10; i++) begin
            btn_a = (i % 2 == 1);
            @(negedge clk);
        end
        fire("bounce",  6'b000_001, 1'b1);

        // Sink the last ship, then presses are ignored.
        fire("sink_all", 6'b110_100, 1'b1);
        fire("after_over", 6'b000_010, 1'b0);

        // Single ship at row 2, col 3.
        clr = 1'b0;
        #1;
        check_reset("clr_a", 4'd15);
        ship = 35'd0;
        ship[21] = 1'b1;
        @(negedge clk);
        clr = 1'b1;
        repeat (4) @(negedge clk);
        model_reset(4'd15);
        fire("single_ship", 6'b010_011, 1'b1);
        fire("single_over", 6'b000_000, 1'b0);

        // Budget instance (MAX_SHOTS = 2).
        sel = 1'b1;
        clr = 1'b0;
        @(negedge clk);
        check_reset("rst_b", 4'd2);
        clr = 1'b1;
        repeat (4) @(negedge clk);
        model_reset(4'd2);
        fire("b_miss0", 6'b000_000, 1'b1);

        // Reset in the middle of CHECK, with the button still held afterwards.
        coord = 6'b000_001;
        btn_b = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        clr = 1'b0;
        #1;
        check_reset("clr_mid", 4'd2);
        @(negedge clk);
        clr = 1'b1;
        model_reset(4'd2);
        repeat (20) @(negedge clk);
        check("held_after_clr.done_count", 64'(done_total), 64'(exp_done));
        check("held_after_clr.shot", 64'(obs_shot), 64'd0);
        btn_b = 1'b1;
        repeat (12) @(negedge clk);

        fire("b_miss1", 6'b000_000, 1'b1);
        fire("b_miss2", 6'b000_001, 1'b1);
`ifdef SHOT_LIMIT_EN
        fire("b_exhausted", 6'b000_010, 1'b0);
`else
        fire("b_unlimited", 6'b000_010, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/modulo_controle_disparo.md
# modulo_controle_disparo

Shot controller for the naval-battle game, directly upstream of the display/LED-matrix stage. Debounces the fire pushbutton, latches the 6-bit coordinate, validates it against the 7×5 board, checks it against the preset ship map, and writes the 35-bit shot and hit maps. It also produces the 2-bit status code and the game-over flag that the display stage consumes.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive identical synchronized samples that must be seen before the button level is accepted.
- `MAX_SHOTS`, default 15: starting value of the shot budget; 4-bit value in the range 1..15.
- `clk` input 1: system clock; all state changes on its rising edge.
- `clr` input 1: asynchronous, active-low reset.
- `button_fire` input 1: raw pushbutton, active-low, asynchronous to `clk`.
- `coord_at` input 6: `[5:3]` = row 0..6, `[2:0]` = column 0..4. Sampled only on an accepted press.
- `ship_map` input 35: preset ship matrix. Bit index = 34 − (5·row + col).
- `shot_map` output 35: cells already fired at. Same bit indexing as `ship_map`.
- `hit_map` output 35: cells fired at that contain a ship.
- `status` output 2: result of the last shot.
  - 00: none.
  - 01: water.
  - 10: hit.
  - 11: invalid or repeated coordinate.
- `shots_left` output 4: remaining shot budget.
- `shot_done` output 1: one-cycle pulse when a shot has been resolved.
- `game_over` output 1: level; asserted once the game has ended.

## Operation
- Input conditioning:
  - 2-flop synchronizer on `button_fire`.
  - Debounce counter: the accepted level changes only after `DEBOUNCE_CYCLES` consecutive equal samples that differ from the current accepted level. Any differing sample restarts the count.
  - Press pulse: one `clk` cycle, generated on the accepted high→low transition.
- FSM states: IDLE, CHECK, UPDATE, OVER.
  - IDLE: on a press pulse, latch `coord_at` into `coord_q` and go to CHECK. Otherwise stay in IDLE.
  - CHECK: compute `valid` = (row ≤ 6 and col ≤ 4), `idx`, `repeat` = `shot_map[idx]`, and `is_ship` = `ship_map[idx]`. Go to UPDATE.
  - UPDATE:
    - Invalid or repeated coordinate: `status` = 11, no map write, budget not consumed.
    - Otherwise: set `shot_map[idx]`, and set `hit_map[idx]` if `is_ship`. `status` = 10 if hit, else 01. Decrement `shots_left`.
    - Pulse `shot_done`.
    - Next state is OVER if the post-update `hit_map` equals `ship_map` (with `ship_map` ≠ 0), or if `shots_left` becomes 0. Otherwise IDLE.
  - OVER: `game_over` = 1. Press pulses are ignored. Maps, `status` and `shots_left` are frozen. Only `clr` leaves this state.
- Press pulses arriving while in CHECK or UPDATE are dropped, not queued.
- `ship_map` is expected to be static between resets. It is sampled in CHECK and again in the all-sunk comparison.

## Timing
- Reset values:
  - State = IDLE.
  - `shot_map` = 0, `hit_map` = 0.
  - `status` = 00.
  - `shots_left` = `MAX_SHOTS`.
  - `shot_done` = 0, `game_over` = 0.
  - Debounced level = 1 (released); debounce counter = 0.
- Latency, from a stable low on `button_fire` to the press pulse: 2 synchronizer cycles + `DEBOUNCE_CYCLES`.
- Latency, from the press pulse to resolution:
  - Press pulse in cycle N: CHECK in N+1, UPDATE in N+2.
  - `shot_done` high in N+2.
  - Updated maps, `status` and `shots_left` visible from N+3.
  - `game_over` high from N+3.
- `clr` asserted mid-operation (any state, including mid-debounce) clears immediately and asynchronously to the reset values. A press that is still held when `clr` releases is not accepted until it is released and pressed again.
- Simultaneous end conditions (last ship sunk on the last shot): `status` = 10, `shots_left` = 0, transition to OVER.

## Configuration
- `SHOT_LIMIT_EN` defined:
  - The shot budget is active.
  - `shots_left` decrements on each valid, non-repeated shot.
  - Reaching 0 ends the game.
- `SHOT_LIMIT_EN` undefined:
  - No budget counter is built; `shots_left` is held at `MAX_SHOTS`.
  - The game ends only when all ships are sunk.

## Test plan
- Reset, then `ship_map` bit 34 set, `coord_at` = 6'b000_000, press held ≥ 2 + `DEBOUNCE_CYCLES` cycles → `shot_map[34]` = 1, `hit_map[34]` = 1, `status` = 10, `shots_left` = 14, one `shot_done` pulse.
- Repeat the same coordinate → `status` = 11, maps unchanged, `shots_left` = 14.
- `coord_at` = 6'b111_000, then 6'b000_101 → `status` = 11 on both, no map write.
- Button bounce: toggle every cycle for 10 cycles, then stable low → exactly one `shot_done`.
- `ship_map` with a single bit at row 2, col 3 (bit 21); fire at 6'b010_011 → `game_over` = 1 at N+3; a further press produces no `shot_done`.
- With `SHOT_LIMIT_EN`, `MAX_SHOTS` = 2, two misses → `shots_left` = 0, `game_over` = 1. Assert `clr` low mid-CHECK → all outputs return to reset values immediately.
